// File: rtl/adder_sched.sv
// rtl/adder_sched.sv - two-requester round-robin scheduler around a single byte-serial adder
// Operands are summed one byte per cycle, LSB first, through one 8-bit add slice.

module adder_sched #(
    parameter  int NBYTES = 4,
    localparam int W      = 8 * NBYTES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req0_cin,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic         req1_cin,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_sum,
    output logic         res_cout,
    output logic         res_id
);

    localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [IDXW-1:0] r_idx;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_sum;
    logic            r_carry;
    logic            r_id;
    logic            r_last_grant;

    logic            w_idle;
    logic            w_grant1;
    logic            w_accept;
    logic            w_last_byte;
    logic [IDXW+2:0] w_off;
    logic [8:0]      w_slice;

    // On a tie the requester that did not win last time is granted.
    assign w_idle      = (r_state == S_IDLE);
    assign w_grant1    = req1_valid && (!req0_valid || !r_last_grant);
    assign req0_ready  = rst_n && w_idle && req0_valid && !w_grant1;
    assign req1_ready  = rst_n && w_idle && w_grant1;
    assign w_accept    = req0_ready || req1_ready;

    assign w_last_byte = (r_idx == IDXW'(NBYTES - 1));
    assign w_off       = {r_idx, 3'b000};
    assign w_slice     = {1'b0, r_a[w_off +: 8]} + {1'b0, r_b[w_off +: 8]} + {8'b0, r_carry};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_ADD;
            S_ADD:   if (w_last_byte) w_next = S_DONE;
            S_DONE:  if (res_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx        <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_sum        <= '0;
            r_carry      <= 1'b0;
            r_id         <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            if (w_accept) begin
                r_a          <= w_grant1 ? req1_a : req0_a;
                r_b          <= w_grant1 ? req1_b : req0_b;
                r_carry      <= w_grant1 ? req1_cin : req0_cin;
                r_id         <= w_grant1;
                r_last_grant <= w_grant1;
                r_idx        <= '0;
            end else if (r_state == S_ADD) begin
                r_sum[w_off +: 8] <= w_slice[7:0];
                r_carry           <= w_slice[8];
                r_idx             <= r_idx + IDXW'(1);
            end
        end
    end

    assign res_valid = (r_state == S_DONE);
    assign res_sum   = r_sum;
    assign res_cout  = r_carry;
    assign res_id    = r_id;

endmodule

// File: tb/tb_adder_sched.sv
// tb/tb_adder_sched.sv - directed and randomized checks of adder_sched against an arithmetic model
// The model tracks the round-robin winner and computes sums with plain wide addition.

module tb_adder_sched;

    localparam int NB = 4;
    localparam int W  = 8 * NB;
    localparam int W1 = W + 1;

    logic         clk;
    logic         rst_n;
    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         req0_cin;
    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         req1_cin;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_sum;
    logic         res_cout;
    logic         res_id;

    int checks = 0;
    int errors = 0;
    bit m_last = 1'b1;

    adder_sched #(.NBYTES(NB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_cin   (req0_cin),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_cin   (req1_cin),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_sum    (res_sum),
        .res_cout   (res_cout),
        .res_id     (res_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic xact(input bit v0, input logic [W-1:0] a0, input logic [W-1:0] b0, input bit c0,
                        input bit v1, input logic [W-1:0] a1, input logic [W-1:0] b1, input bit c1,
                        input int hold);
        bit          g;
        logic [W:0]  e;
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_cin = c0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_cin = c1;
        res_ready  = (hold == 0);
        g = (v0 && v1) ? !m_last : v1;
        e = g ? ({1'b0, a1} + {1'b0, b1} + W1'(c1)) : ({1'b0, a0} + {1'b0, b0} + W1'(c0));
        #1;
        chk("grant_ready0", W'(req0_ready), W'(!g));
        chk("grant_ready1", W'(req1_ready), W'(g));
        step();
        m_last = g;
        // Operands change right after acceptance; the result must not follow them.
        req0_a = $urandom; req0_b = $urandom; req0_cin = 1'($urandom);
        req1_a = $urandom; req1_b = $urandom; req1_cin = 1'($urandom);
        for (int k = 0; k < NB; k++) begin
            chk("busy_res_valid", W'(res_valid), W'(0));
            chk("busy_ready0", W'(req0_ready), W'(0));
            chk("busy_ready1", W'(req1_ready), W'(0));
            step();
        end
        chk("done_res_valid", W'(res_valid), W'(1));
        chk("done_sum", res_sum, e[W-1:0]);
        chk("done_cout", W'(res_cout), W'(e[W]));
        chk("done_id", W'(res_id), W'(g));
        for (int h = 0; h < hold; h++) begin
            step();
            chk("hold_res_valid", W'(res_valid), W'(1));
            chk("hold_sum", res_sum, e[W-1:0]);
            chk("hold_cout", W'(res_cout), W'(e[W]));
            chk("hold_id", W'(res_id), W'(g));
            chk("hold_ready0", W'(req0_ready), W'(0));
            chk("hold_ready1", W'(req1_ready), W'(0));
        end
        res_ready = 1'b1;
        step();
        chk("consumed_res_valid", W'(res_valid), W'(0));
    endtask

    initial begin
        rst_n = 1'b0;
        res_ready = 1'b0;
        req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
        req1_valid = 1'b1; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
        #12;
        chk("rst_ready0", W'(req0_ready), W'(0));
        chk("rst_ready1", W'(req1_ready), W'(0));
        chk("rst_res_valid", W'(res_valid), W'(0));
        chk("rst_sum", res_sum, W'(0));
        chk("rst_cout", W'(res_cout), W'(0));
        chk("rst_id", W'(res_id), W'(0));
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("idle_ready0", W'(req0_ready), W'(0));
        chk("idle_ready1", W'(req1_ready), W'(0));

        xact(1'b1, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0, '0, '0, 1'b0, 0);
        xact(1'b0, '0, '0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0);

        // Both requesters valid back to back: service alternates with no idle cycle.
        for (int i = 0; i < 3; i++)
            xact(1'b1, $urandom, $urandom, 1'($urandom), 1'b1, $urandom, $urandom, 1'($urandom), 0);

        xact(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, $urandom, $urandom, 1'b0, 5);

        for (int i = 0; i < 20; i++) begin
            bit v0;
            bit v1;
            v0 = 1'($urandom_range(0, 1));
            v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
            xact(v0, $urandom, $urandom, 1'($urandom), v1, $urandom, $urandom, 1'($urandom),
                 int'($urandom_range(0, 2)));
        end

        // Reset in the middle of an addition aborts it.
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_a = 32'h1234_5678; req0_b = 32'h1111_1111; req0_cin = 1'b0;
        res_ready = 1'b1;
        #1;
        chk("abort_accept_ready0", W'(req0_ready), W'(1));
        step();
        m_last = 1'b0;
        req0_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        m_last = 1'b1;
        chk("abort_ready0", W'(req0_ready), W'(0));
        chk("abort_ready1", W'(req1_ready), W'(0));
        chk("abort_res_valid", W'(res_valid), W'(0));
        chk("abort_sum", res_sum, W'(0));
        chk("abort_cout", W'(res_cout), W'(0));
        chk("abort_id", W'(res_id), W'(0));
        step();
        step();
        chk("abort_no_result", W'(res_valid), W'(0));
        rst_n = 1'b1;
        xact(1'b1, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b1, $urandom, $urandom, 1'b0, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();
        chk("final_res_valid", W'(res_valid), W'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
